// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Tracks in-flight register writes through the EXE, MEM and WB
//            pipeline slots. Exports the MEM/WB destination pairs to the
//            forwarding selector. Raises a combinational stall for the
//            ID-stage instruction when forwarding cannot satisfy its sources.
// Options  : Define HAZARD_STALL_COUNTER_EN to add a saturating stall-cycle
//            counter (ports clrCountIn / stallCountOut).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freezeIn,
  input  logic                  flushIn,
  input  logic                  forwardEnIn,
  input  logic                  idWbEnIn,
  input  logic                  idMemRIn,
  input  logic [REG_ADDR_W-1:0] idDestIn,
  input  logic [REG_ADDR_W-1:0] src1In,
  input  logic [REG_ADDR_W-1:0] src2In,
  input  logic                  src1ValidIn,
  input  logic                  src2ValidIn,
  output logic                  hazardOut,
  output logic                  exeWbEnOut,
  output logic [REG_ADDR_W-1:0] exeDestOut,
  output logic                  memWbEnOut,
  output logic [REG_ADDR_W-1:0] memDestOut,
  output logic                  wbWbEnOut,
  output logic [REG_ADDR_W-1:0] wbDestOut
`ifdef HAZARD_STALL_COUNTER_EN
  ,
  input  logic                  clrCountIn,
  output logic [STALL_CNT_W-1:0] stallCountOut
`endif
);

  // --------------------------------------------------------------------------
  // Slot state. Only the EXE slot needs the load flag: load-use is the only
  // hazard forwarding cannot cover, and it only matters while the load is in
  // EXE. MEM and WB therefore keep just {wbEn, dest}.
  // --------------------------------------------------------------------------
  logic                  r_exeWbEn;
  logic                  r_exeMemR;
  logic [REG_ADDR_W-1:0] r_exeDest;
  logic                  r_memWbEn;
  logic [REG_ADDR_W-1:0] r_memDest;
  logic                  r_wbWbEn;
  logic [REG_ADDR_W-1:0] r_wbDest;

  // --------------------------------------------------------------------------
  // Source matching against each slot that can cause a stall. WB is never
  // checked: the register file writes before it is read in the same cycle.
  // --------------------------------------------------------------------------
  logic w_src1MatchExe;
  logic w_src2MatchExe;
  logic w_src1MatchMem;
  logic w_src2MatchMem;
  logic w_matchExe;
  logic w_matchMem;
  logic w_hazard;
  logic w_bubbleIntoExe;

  assign w_src1MatchExe = src1ValidIn && (src1In == r_exeDest) && r_exeWbEn;
  assign w_src2MatchExe = src2ValidIn && (src2In == r_exeDest) && r_exeWbEn;
  assign w_src1MatchMem = src1ValidIn && (src1In == r_memDest) && r_memWbEn;
  assign w_src2MatchMem = src2ValidIn && (src2In == r_memDest) && r_memWbEn;

  // A source pair both hitting the same slot collapses into one hazard.
  assign w_matchExe = w_src1MatchExe || w_src2MatchExe;
  assign w_matchMem = w_src1MatchMem || w_src2MatchMem;

  // Select the stall rule: with forwarding only an EXE-stage load blocks the
  // consumer; without it any producer still in EXE or MEM does.
  always_comb begin
    w_hazard = 1'b0;
    if (forwardEnIn) begin
      w_hazard = w_matchExe && r_exeMemR;
    end else begin
      w_hazard = w_matchExe || w_matchMem;
    end
  end

  assign hazardOut = w_hazard;

  // A squashed or stalled ID instruction must not enter EXE.
  assign w_bubbleIntoExe = flushIn || w_hazard;

  // --------------------------------------------------------------------------
  // Slot pipeline. Freeze holds every slot and masks flush/hazard for that
  // cycle; the pipeline re-presents flush once the freeze releases.
  // --------------------------------------------------------------------------

  // Advance EXE -> MEM -> WB and load EXE from ID (or a bubble) when not frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exeWbEn <= 1'b0;
      r_exeMemR <= 1'b0;
      r_exeDest <= '0;
      r_memWbEn <= 1'b0;
      r_memDest <= '0;
      r_wbWbEn  <= 1'b0;
      r_wbDest  <= '0;
    end else if (!freezeIn) begin
      r_wbWbEn  <= r_memWbEn;
      r_wbDest  <= r_memDest;
      r_memWbEn <= r_exeWbEn;
      r_memDest <= r_exeDest;
      if (w_bubbleIntoExe) begin
        r_exeWbEn <= 1'b0;
        r_exeMemR <= 1'b0;
        r_exeDest <= '0;
      end else begin
        r_exeWbEn <= idWbEnIn;
        // A load that writes nothing cannot create a load-use hazard.
        r_exeMemR <= idMemRIn && idWbEnIn;
        r_exeDest <= idDestIn;
      end
    end
  end

  // Slot outputs are direct reads of the registered slot contents.
  assign exeWbEnOut = r_exeWbEn;
  assign exeDestOut = r_exeDest;
  assign memWbEnOut = r_memWbEn;
  assign memDestOut = r_memDest;
  assign wbWbEnOut  = r_wbWbEn;
  assign wbDestOut  = r_wbDest;

  // --------------------------------------------------------------------------
  // Optional stall-cycle counter.
  // --------------------------------------------------------------------------
`ifdef HAZARD_STALL_COUNTER_EN
  logic [STALL_CNT_W-1:0] r_stallCnt;
  logic                   w_stallCntFull;

  assign w_stallCntFull = &r_stallCnt;

  // Count cycles where a stall really held the front end; saturate at all-ones
  // and let a clear win over a simultaneous increment.
  always_ff @(posedge clk) begin
    if (rst || clrCountIn) begin
      r_stallCnt <= '0;
    end else if (w_hazard && !freezeIn && !w_stallCntFull) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign stallCountOut = r_stallCnt;
`else
  // The counter width has no consumer in this build.
  logic w_unused_stallCntW;
  assign w_unused_stallCntW = (STALL_CNT_W != 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Self-checking bench for hazard_scoreboard: directed vector table,
//            hand-written reset/counter sequences and a randomized run against
//            a queue-based pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int RW = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, freezeIn, flushIn, forwardEnIn;
  logic          idWbEnIn, idMemRIn, src1ValidIn, src2ValidIn;
  logic [RW-1:0] idDestIn, src1In, src2In;
  logic          hazardOut, exeWbEnOut, memWbEnOut, wbWbEnOut;
  logic [RW-1:0] exeDestOut, memDestOut, wbDestOut;
`ifdef HAZARD_STALL_COUNTER_EN
  logic          clrCountIn;
  logic [CW-1:0] stallCountOut;
`endif

  hazard_scoreboard #(.REG_ADDR_W(RW), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .freezeIn(freezeIn), .flushIn(flushIn),
    .forwardEnIn(forwardEnIn), .idWbEnIn(idWbEnIn), .idMemRIn(idMemRIn),
    .idDestIn(idDestIn), .src1In(src1In), .src2In(src2In),
    .src1ValidIn(src1ValidIn), .src2ValidIn(src2ValidIn),
    .hazardOut(hazardOut), .exeWbEnOut(exeWbEnOut), .exeDestOut(exeDestOut),
    .memWbEnOut(memWbEnOut), .memDestOut(memDestOut),
    .wbWbEnOut(wbWbEnOut), .wbDestOut(wbDestOut)
`ifdef HAZARD_STALL_COUNTER_EN
    , .clrCountIn(clrCountIn), .stallCountOut(stallCountOut)
`endif
  );

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit fr, input bit fl, input bit fwd, input bit we,
                       input bit mr, input bit [RW-1:0] dst, input bit [RW-1:0] s1,
                       input bit [RW-1:0] s2, input bit v1, input bit v2);
    freezeIn = fr; flushIn = fl; forwardEnIn = fwd; idWbEnIn = we; idMemRIn = mr;
    idDestIn = dst; src1In = s1; src2In = s2; src1ValidIn = v1; src2ValidIn = v2;
  endtask

  // Destinations are only meaningful for slots that write.
  task automatic chk_slots(input string tag, input bit ew, input bit [RW-1:0] ed,
                           input bit mw, input bit [RW-1:0] md,
                           input bit ww, input bit [RW-1:0] wd);
    chk({tag, " exeWbEn"}, {31'd0, exeWbEnOut}, {31'd0, ew});
    if (ew) chk({tag, " exeDest"}, {28'd0, exeDestOut}, {28'd0, ed});
    chk({tag, " memWbEn"}, {31'd0, memWbEnOut}, {31'd0, mw});
    if (mw) chk({tag, " memDest"}, {28'd0, memDestOut}, {28'd0, md});
    chk({tag, " wbWbEn"}, {31'd0, wbWbEnOut}, {31'd0, ww});
    if (ww) chk({tag, " wbDest"}, {28'd0, wbDestOut}, {28'd0, wd});
  endtask

  // Directed vector: inputs applied, hazard checked before the edge,
  // slot contents checked after the edge.
  typedef struct {
    bit fr, fl, fwd, we, mr;
    bit [RW-1:0] dst, s1, s2;
    bit v1, v2;
    bit hz;
    bit ew; bit [RW-1:0] ed;
    bit mw; bit [RW-1:0] md;
    bit ww; bit [RW-1:0] wd;
  } vec_t;

  vec_t vt[19];

  // Reference model: a 3-deep queue, index 0 = EXE, 1 = MEM, 2 = WB.
  typedef struct { bit we; bit mr; bit [RW-1:0] d; } slot_t;
  slot_t pipe[$];
  int    ref_cnt;

  function automatic bit ref_hazard(input bit fwd, input bit [RW-1:0] s1, input bit v1,
                                    input bit [RW-1:0] s2, input bit v2);
    int depth = fwd ? 1 : 2;
    for (int i = 0; i < depth; i++) begin
      if (pipe[i].we && (!fwd || pipe[i].mr) &&
          ((v1 && s1 == pipe[i].d) || (v2 && s2 == pipe[i].d)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
`ifdef HAZARD_STALL_COUNTER_EN
    clrCountIn = 1'b0;
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    //                fr fl fw we mr dst s1 s2 v1 v2 hz  ew ed mw md ww wd
    vt[0]  = '{0, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0}; // load R3
    vt[1]  = '{0, 0, 1, 1, 0, 4, 3, 0, 1, 0, 1, 0, 0, 1, 3, 0, 0}; // add uses R3
    vt[2]  = '{0, 0, 1, 1, 0, 4, 3, 0, 1, 0, 0, 1, 4, 0, 0, 1, 3}; // add enters
    vt[3]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0};
    vt[4]  = '{0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 5, 0, 0, 1, 4}; // write R5
    vt[5]  = '{0, 0, 0, 1, 0, 6, 0, 5, 0, 1, 1, 0, 0, 1, 5, 0, 0}; // reads R5
    vt[6]  = '{0, 0, 0, 1, 0, 6, 0, 5, 0, 1, 1, 0, 0, 0, 0, 1, 5};
    vt[7]  = '{0, 0, 0, 1, 0, 6, 0, 5, 0, 1, 0, 1, 6, 0, 0, 0, 0}; // reader enters
    vt[8]  = '{0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 1, 2, 1, 6, 0, 0}; // load R2
    vt[9]  = '{1, 0, 1, 1, 0, 8, 2, 2, 1, 1, 1, 1, 2, 1, 6, 0, 0}; // frozen x3
    vt[10] = '{1, 0, 1, 1, 0, 8, 2, 2, 1, 1, 1, 1, 2, 1, 6, 0, 0};
    vt[11] = '{1, 0, 1, 1, 0, 8, 2, 2, 1, 1, 1, 1, 2, 1, 6, 0, 0};
    vt[12] = '{0, 0, 1, 1, 0, 8, 2, 2, 1, 1, 1, 0, 0, 1, 2, 1, 6}; // one bubble
    vt[13] = '{0, 0, 1, 1, 0, 8, 2, 2, 1, 1, 0, 1, 8, 0, 0, 1, 2};
    vt[14] = '{0, 1, 1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0}; // flush R7
    vt[15] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8};
    vt[16] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[17] = '{1, 1, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // freeze+flush
    vt[18] = '{0, 1, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("reset hazard", {31'd0, hazardOut}, 32'd0);
    chk_slots("reset", 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STALL_COUNTER_EN
    chk("reset count", {30'd0, stallCountOut}, 32'd0);
`endif
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].fr, vt[i].fl, vt[i].fwd, vt[i].we, vt[i].mr,
            vt[i].dst, vt[i].s1, vt[i].s2, vt[i].v1, vt[i].v2);
      #1;
      chk($sformatf("vec%0d hazard", i), {31'd0, hazardOut}, {31'd0, vt[i].hz});
      @(posedge clk);
      #1;
      chk_slots($sformatf("vec%0d", i), vt[i].ew, vt[i].ed, vt[i].mw, vt[i].md,
                vt[i].ww, vt[i].wd);
    end

    // Reset in the middle of a load-use stall discards everything.
    drive(0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 0, 4, 1, 0, 1, 0);
    #1;
    chk("midstall hazard", {31'd0, hazardOut}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("postreset hazard", {31'd0, hazardOut}, 32'd0);
    chk_slots("postreset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Randomized run against the queue model; the DUT starts empty here.
    pipe.delete();
    repeat (3) pipe.push_back('{1'b0, 1'b0, '0});
    ref_cnt = 0;
    begin
      bit fwd;
      fwd = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        bit fr, fl, we, mr, v1, v2, hz, clr;
        bit [RW-1:0] dst, s1, s2;
        slot_t n;
        if (c % 64 == 0) fwd = $urandom_range(0, 1);
        fr  = ($urandom_range(0, 7) == 0);
        fl  = ($urandom_range(0, 7) == 0);
        we  = ($urandom_range(0, 3) != 0);
        mr  = ($urandom_range(0, 2) == 0);
        dst = $urandom_range(0, 3);
        s1  = $urandom_range(0, 3);
        s2  = $urandom_range(0, 3);
        v1  = $urandom_range(0, 1);
        v2  = $urandom_range(0, 1);
        clr = ($urandom_range(0, 15) == 0);
        drive(fr, fl, fwd, we, mr, dst, s1, s2, v1, v2);
`ifdef HAZARD_STALL_COUNTER_EN
        clrCountIn = clr;
`endif
        hz = ref_hazard(fwd, s1, v1, s2, v2);
        #1;
        chk("rand hazard", {31'd0, hazardOut}, {31'd0, hz});
        if (!fr) begin
          n = (fl || hz) ? '{1'b0, 1'b0, '0} : '{we, mr && we, dst};
          pipe.push_front(n);
          void'(pipe.pop_back());
        end
        if (clr) ref_cnt = 0;
        else if (hz && !fr && ref_cnt < (1 << CW) - 1) ref_cnt++;
        @(posedge clk); #1;
        chk_slots("rand", pipe[0].we, pipe[0].d, pipe[1].we, pipe[1].d,
                  pipe[2].we, pipe[2].d);
`ifdef HAZARD_STALL_COUNTER_EN
        chk("rand count", {30'd0, stallCountOut}, ref_cnt);
`endif
      end
    end

`ifdef HAZARD_STALL_COUNTER_EN
    // Saturation: five non-frozen hazard cycles on a 2-bit counter.
    clrCountIn = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int seen = 0;
      int guard = 0;
      drive(0, 0, 0, 1, 0, 1, 1, 0, 1, 0);
      while (seen < 5 && guard < 40) begin
        #1;
        if (hazardOut) seen++;
        @(posedge clk); #1;
        guard++;
      end
      chk("stall cycles seen", seen, 5);
      chk("count saturated", {30'd0, stallCountOut}, 32'd3);
      guard = 0;
      while (!hazardOut && guard < 10) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("hazard before clear", {31'd0, hazardOut}, 32'd1);
      clrCountIn = 1'b1;
      @(posedge clk); #1;
      chk("clear beats increment", {30'd0, stallCountOut}, 32'd0);
      clrCountIn = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
